// File: rtl/wishbone_master_arbiter.sv
// wishbone_master_arbiter
//
// Shares one wishbone bus between two masters: m0 (host path behind the UART
// handler) and m1 (local DMA / self-test master). Ownership is granted for a
// whole bus cycle (cyc held high) and alternates round-robin on contention.
// A stall watchdog ends a cycle that never gets acked, so a dead slave cannot
// lock the bus.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   m0_* / m1_*  (inputs)    we, cyc, stb, adr, dat from each master
//   m0_* / m1_*  (outputs)   dat (read data), ack, int (copy of s_int_i)
//   s_we_o, s_cyc_o, s_stb_o, s_adr_o, s_dat_o   muxed request to interconnect
//   s_dat_i, s_ack_i, s_int_i                     response from interconnect
//   grant_o                  one-hot owner {m1,m0}; 00 when idle
//   timeout_o                one-cycle pulse when the watchdog fires
module wishbone_master_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_we_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_int_o,

    input  logic                  m1_we_i,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_int_o,

    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_int_i,

    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Watchdog fires on the TIMEOUT_CYCLES-th stalled strobe cycle, i.e. when
    // the counter already holds TIMEOUT_CYCLES-1 and this cycle is stalled too.
    localparam logic        WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    state_t      state, state_nxt;
    logic        last_owner, last_owner_nxt;    // 0 = m0, 1 = m1
    logic        drain_owner, drain_owner_nxt;  // master being drained after a timeout
    logic [15:0] wd_cnt, wd_cnt_nxt;

    logic                  cur;
    logic                  own;
    logic                  cur_we, cur_cyc, cur_stb;
    logic [ADDR_WIDTH-1:0] cur_adr;
    logic [DATA_WIDTH-1:0] cur_dat;
    logic                  wd_fire;

    assign m0_int_o = s_int_i;
    assign m1_int_o = s_int_i;

    assign own     = (state == OWN0) || (state == OWN1);
    assign cur     = (state == OWN1);
    assign cur_we  = cur ? m1_we_i  : m0_we_i;
    assign cur_cyc = cur ? m1_cyc_i : m0_cyc_i;
    assign cur_stb = cur ? m1_stb_i : m0_stb_i;
    assign cur_adr = cur ? m1_adr_i : m0_adr_i;
    assign cur_dat = cur ? m1_dat_i : m0_dat_i;

    assign wd_fire = WD_EN && own && cur_stb && !s_ack_i && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_owner  <= 1'b1;   // m0 wins the first tie after reset
            drain_owner <= 1'b0;
            wd_cnt      <= 16'd0;
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            drain_owner <= drain_owner_nxt;
            wd_cnt      <= wd_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        last_owner_nxt  = last_owner;
        drain_owner_nxt = drain_owner;
        wd_cnt_nxt      = 16'd0;

        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m0_dat_o  = '0;
        m1_dat_o  = '0;
        grant_o   = 2'b00;
        timeout_o = 1'b0;

        case (state)
            IDLE: begin
                // s_ack_i is ignored here; nothing is forwarded.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end

            OWN0, OWN1: begin
                grant_o = cur ? 2'b10 : 2'b01;
                if (wd_fire) begin
                    // Terminate the stalled cycle towards the master with an
                    // all-ones ack and take the bus away from the slave.
                    timeout_o       = 1'b1;
                    state_nxt       = DRAIN;
                    drain_owner_nxt = cur;
                    if (cur) begin
                        m1_ack_o = 1'b1;
                        m1_dat_o = '1;
                    end else begin
                        m0_ack_o = 1'b1;
                        m0_dat_o = '1;
                    end
                end else begin
                    s_we_o  = cur_we;
                    s_cyc_o = cur_cyc;
                    s_stb_o = cur_stb;
                    s_adr_o = cur_adr;
                    s_dat_o = cur_dat;
                    if (cur) begin
                        m1_ack_o = s_ack_i;
                        m1_dat_o = s_dat_i;
                    end else begin
                        m0_ack_o = s_ack_i;
                        m0_dat_o = s_dat_i;
                    end
                    if (cur_stb && !s_ack_i) begin
                        wd_cnt_nxt = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;
                    end
                    // An ack in the same cycle as cyc falling is still
                    // forwarded above; the release follows on the next edge.
                    if (!cur_cyc) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = cur;
                    end
                end
            end

            DRAIN: begin
                // Bus is quiet; late acks are dropped until the master lets go.
                grant_o = drain_owner ? 2'b10 : 2'b01;
                if (!(drain_owner ? m1_cyc_i : m0_cyc_i)) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = drain_owner;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Directed bench for wishbone_master_arbiter with an ack scoreboard.
module tb_wishbone_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_we_i, m0_cyc_i, m0_stb_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i, m0_dat_o;
    logic          m0_ack_o, m0_int_o;
    logic          m1_we_i, m1_cyc_i, m1_stb_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i, m1_dat_o;
    logic          m1_ack_o, m1_int_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o, s_dat_i;
    logic          s_ack_i, s_int_i;
    logic [1:0]    grant_o;
    logic          timeout_o;

    wishbone_master_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_int_o(m0_int_o),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_int_o(m1_int_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_int_i(s_int_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          id;    // 0 = m0, 1 = m1
        logic [DW-1:0] dat;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Every ack seen by a master must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (m0_ack_o || m1_ack_o) begin
            check("ack_both", 64'(m0_ack_o & m1_ack_o), 64'd0);
            if (sb.size() == 0) begin
                check("ack_unexpected", 64'({m1_ack_o, m0_ack_o}), 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 64'(m1_ack_o), 64'(e.id));
                check("ack_data", 64'(e.id ? m1_dat_o : m0_dat_o), 64'(e.dat));
                check("other_dat", 64'(e.id ? m0_dat_o : m1_dat_o), 64'd0);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic set_m0(input logic cyc, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m0_cyc_i = cyc; m0_stb_i = cyc; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    endtask

    task automatic set_m1(input logic cyc, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        m1_cyc_i = cyc; m1_stb_i = cyc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    endtask

    task automatic ack_beat(input logic id, input logic [DW-1:0] rdata);
        s_ack_i = 1'b1;
        s_dat_i = rdata;
        sb.push_back('{id: id, dat: rdata});
    endtask

    initial begin
        set_m0(0, 0, '0, '0);
        set_m1(0, 0, '0, '0);
        s_ack_i = 1'b0; s_dat_i = '0; s_int_i = 1'b0;

        // Reset state: outputs quiet even with a stray ack on the bus
        repeat (2) nxt();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("rst_grant", grant_o, 2'b00);
        check("rst_cyc", s_cyc_o, 1'b0);
        check("rst_timeout", timeout_o, 1'b0);
        check("rst_m0_ack", m0_ack_o, 1'b0);
        check("rst_m0_dat", m0_dat_o, 32'h0);
        s_ack_i = 1'b0; s_dat_i = '0;
        nxt();
        rst = 1'b0;
        s_int_i = 1'b1; #1;
        check("int_m0", m0_int_o, 1'b1);
        check("int_m1", m1_int_o, 1'b1);
        s_int_i = 1'b0; #1;
        check("int_m0_low", m0_int_o, 1'b0);

        // m0 single write
        nxt();
        set_m0(1, 1, 32'h0100_0000, 32'h5); #1;
        check("t1_latency_cyc", s_cyc_o, 1'b0);
        nxt();
        check("t1_grant", grant_o, 2'b01);
        check("t1_cyc", s_cyc_o, 1'b1);
        check("t1_we", s_we_o, 1'b1);
        check("t1_adr", s_adr_o, 32'h0100_0000);
        check("t1_dat", s_dat_o, 32'h5);
        ack_beat(0, 32'h0); #1;
        check("t1_ack", m0_ack_o, 1'b1);
        nxt();
        s_ack_i = 1'b0; set_m0(0, 0, '0, '0); #1;
        check("t1_release_cyc", s_cyc_o, 1'b0);
        nxt();
        check("t1_idle", grant_o, 2'b00);

        // Simultaneous requests right after a reset
        rst = 1'b1; #1;
        check("t2_rst_grant", grant_o, 2'b00);
        nxt();
        rst = 1'b0;
        set_m0(1, 1, 32'h0000_00A0, 32'h11);
        set_m1(1, 1, 32'h0000_00A1, 32'h22);
        nxt();
        check("t2_first_m0", grant_o, 2'b01);
        check("t2_adr_m0", s_adr_o, 32'h0000_00A0);
        ack_beat(0, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m0(0, 0, '0, '0);
        nxt();
        check("t2_dead_grant", grant_o, 2'b00);
        check("t2_dead_cyc", s_cyc_o, 1'b0);
        nxt();
        check("t2_then_m1", grant_o, 2'b10);
        check("t2_adr_m1", s_adr_o, 32'h0000_00A1);
        check("t2_dat_m1", s_dat_o, 32'h22);
        ack_beat(1, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m1(0, 0, '0, '0);
        nxt();
        set_m0(1, 1, 32'h0000_00B0, 32'h33);
        set_m1(1, 1, 32'h0000_00B1, 32'h44);
        #1;
        check("t2_idle2", grant_o, 2'b00);
        nxt();
        check("t2_tie2_m0", grant_o, 2'b01);
        ack_beat(0, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m0(0, 0, '0, '0);
        nxt();
        nxt();
        check("t2_m1_after", grant_o, 2'b10);
        ack_beat(1, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m1(0, 0, '0, '0);
        nxt();

        // m1 burst of four reads while m0 waits
        set_m1(1, 0, 32'h0000_2000, '0);
        nxt();
        check("t3_grant_m1", grant_o, 2'b10);
        for (int b = 0; b < 4; b++) begin
            ack_beat(1, 32'h0000_1000 + 32'(b));
            if (b == 0) set_m0(1, 1, 32'h0000_3000, 32'h55);
            #1;
            check("t3_hold", grant_o, 2'b10);
            check("t3_m0_no_ack", m0_ack_o, 1'b0);
            nxt();
        end
        s_ack_i = 1'b0; set_m1(0, 0, '0, '0);
        nxt();
        check("t3_dead", grant_o, 2'b00);
        nxt();
        check("t3_m0_served", grant_o, 2'b01);
        check("t3_m0_adr", s_adr_o, 32'h0000_3000);
        ack_beat(0, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m0(0, 0, '0, '0);
        nxt();

        // Watchdog: slave never acks m0
        set_m0(1, 1, 32'h0000_4000, 32'h66);
        nxt();
        for (int k = 1; k < TO; k++) begin
            #1;
            check("t4_pre_timeout", timeout_o, 1'b0);
            check("t4_pre_cyc", s_cyc_o, 1'b1);
            nxt();
        end
        sb.push_back('{id: 1'b0, dat: 32'hFFFF_FFFF});
        #1;
        check("t4_timeout", timeout_o, 1'b1);
        check("t4_ack", m0_ack_o, 1'b1);
        check("t4_cyc_drop", s_cyc_o, 1'b0);
        check("t4_stb_drop", s_stb_o, 1'b0);
        nxt();
        s_ack_i = 1'b1; s_dat_i = 32'h1234_5678; #1;
        check("t4_pulse_end", timeout_o, 1'b0);
        check("t4_drain_cyc", s_cyc_o, 1'b0);
        check("t4_late_ack", m0_ack_o, 1'b0);
        nxt();
        s_ack_i = 1'b0; s_dat_i = '0;
        check("t4_drain_hold", grant_o, 2'b01);
        set_m0(0, 0, '0, '0);
        nxt();
        check("t4_idle", grant_o, 2'b00);

        // Asynchronous reset in the middle of an m1 cycle
        set_m1(1, 1, 32'h0000_5000, 32'h77);
        nxt();
        check("t5_grant_m1", grant_o, 2'b10);
        check("t5_stb", s_stb_o, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_cyc", s_cyc_o, 1'b0);
        check("t5_rst_grant", grant_o, 2'b00);
        set_m1(0, 0, '0, '0);
        nxt();
        rst = 1'b0;
        set_m0(1, 1, 32'h0000_6000, 32'h88);
        set_m1(1, 0, 32'h0000_7000, '0);
        nxt();
        check("t5_tie_m0", grant_o, 2'b01);
        ack_beat(0, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m0(0, 0, '0, '0);
        nxt();

        // m1 read returns data only to m1
        nxt();
        check("t6_grant_m1", grant_o, 2'b10);
        ack_beat(1, 32'hDEAD_BEEF);
        #1;
        check("t6_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
        check("t6_m1_ack", m1_ack_o, 1'b1);
        check("t6_m0_dat", m0_dat_o, 32'h0);
        nxt();
        s_ack_i = 1'b0; set_m1(0, 0, '0, '0);
        nxt();
        check("t6_m1_dat_idle", m1_dat_o, 32'h0);
        nxt();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
